// File: rtl/display_scan_timer.sv
// Scan timer for multiplexed seven-segment displays: steps the digit index once per slot,
// requests a shift-register load at each slot start and releases blanking by brightness.
module display_scan_timer #(
  parameter int NUM_DIGITS  = 4,
  parameter int CLK_DIVIDE  = 12000,
  parameter int LOAD_CYCLES = 17
) (
  input  logic                          sysclk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [6:0]                    brightness,
  input  logic                          load_done,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_sel,
  output logic                          blank,
  output logic                          load_req,
  output logic                          frame_start,
  output logic                          load_timeout
);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(CLK_DIVIDE);
  // Wide enough for b_lat*CLK_DIVIDE and LOAD_CYCLES+CLK_DIVIDE without truncation
  localparam int RW = $clog2(CLK_DIVIDE * 100 + LOAD_CYCLES + 1) + 1;

  logic [CW-1:0] cnt;
  logic          active;
  logic          load_pend;
  logic [6:0]    b_lat;
  logic [6:0]    b_clamp;
  logic [RW-1:0] on_time;
  logic [RW-1:0] r_comb;
  logic [RW-1:0] r_reg;
  logic [RW-1:0] r_use;
  logic [RW-1:0] cnt_ahead;
  logic          slot_end;
  logic          pend_clear;
  logic          release_hit;
  logic [DW-1:0] digit_next;

  always_comb begin
    b_clamp     = (brightness > 7'd100) ? 7'd100 : brightness;
    on_time     = (RW'(b_lat) * RW'(CLK_DIVIDE)) / RW'(100);
    r_comb      = RW'(LOAD_CYCLES) + RW'(CLK_DIVIDE) - on_time;
    // r_reg only becomes valid after the slot-start cycle, so bypass it there
    r_use       = (cnt == '0) ? r_comb : r_reg;
    cnt_ahead   = RW'(cnt) + RW'(1);
    slot_end    = (cnt == CW'(CLK_DIVIDE - 1));
    pend_clear  = ~load_pend | load_done;
    release_hit = (cnt_ahead >= r_use) & pend_clear;
    digit_next  = (digit_sel == DW'(NUM_DIGITS - 1)) ? '0 : digit_sel + DW'(1);
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      active       <= 1'b0;
      load_pend    <= 1'b0;
      b_lat        <= '0;
      r_reg        <= '0;
      digit_sel    <= '0;
      blank        <= 1'b1;
      load_req     <= 1'b0;
      frame_start  <= 1'b0;
      load_timeout <= 1'b0;
    end else if (!en) begin
      cnt          <= '0;
      active       <= 1'b0;
      load_pend    <= 1'b0;
      digit_sel    <= '0;
      blank        <= 1'b1;
      load_req     <= 1'b0;
      frame_start  <= 1'b0;
      load_timeout <= 1'b0;
    end else if (!active || slot_end) begin
      // Next cycle is a slot start; a load_done seen now belongs to the slot ending
      cnt       <= '0;
      active    <= 1'b1;
      load_pend <= 1'b1;
      b_lat     <= b_clamp;
      blank     <= 1'b1;
      load_req  <= 1'b1;
      if (!active) begin
        digit_sel    <= '0;
        frame_start  <= 1'b1;
        load_timeout <= 1'b0;
      end else begin
        digit_sel    <= digit_next;
        frame_start  <= (digit_next == '0);
        load_timeout <= load_pend & ~load_done;
      end
    end else begin
      cnt          <= cnt + CW'(1);
      r_reg        <= r_comb;
      load_req     <= 1'b0;
      frame_start  <= 1'b0;
      load_timeout <= 1'b0;
      if (load_done) begin
        load_pend <= 1'b0;
      end
      blank <= blank & ~release_hit;
    end
  end

endmodule

// File: tb/tb_display_scan_timer.sv
// Scoreboard bench for display_scan_timer: per-slot expectations are queued by the stimulus
// and checked by a monitor that opens a slot record on every load_req.
module tb_display_scan_timer;
  localparam int ND = 3;
  localparam int CD = 100;
  localparam int LC = 5;

  logic       sysclk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [6:0] brightness;
  logic       load_done;
  logic [1:0] digit_sel;
  logic       blank, load_req, frame_start, load_timeout;

  logic       en2;
  logic [6:0] brightness2;
  logic       load_done2;
  logic [1:0] digit_sel2;
  logic       blank2, load_req2, frame_start2, load_timeout2;

  display_scan_timer #(.NUM_DIGITS(ND), .CLK_DIVIDE(CD), .LOAD_CYCLES(LC)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .en(en), .brightness(brightness), .load_done(load_done),
    .digit_sel(digit_sel), .blank(blank), .load_req(load_req), .frame_start(frame_start),
    .load_timeout(load_timeout)
  );

  display_scan_timer dut_ref (
    .sysclk(sysclk), .rst_n(rst_n), .en(en2), .brightness(brightness2), .load_done(load_done2),
    .digit_sel(digit_sel2), .blank(blank2), .load_req(load_req2), .frame_start(frame_start2),
    .load_timeout(load_timeout2)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    int digit;
    int fs;
    int to;
    int len;
    int low;
    int first;
  } slot_t;

  slot_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    flush_cnt = 0;
  int    flush_seen = 0;
  int    slot_idx = 0;
  bit    open = 0;
  int    cur_digit, cur_fs, cur_to, cyc, low_cnt, first_low, stray;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic push(input int d, input int fs, input int to, input int len, input int low, input int first);
    slot_t e;
    e.digit = d; e.fs = fs; e.to = to; e.len = len; e.low = low; e.first = first;
    exp_q.push_back(e);
  endtask

  task automatic finalize();
    slot_t e;
    slot_idx++;
    $display("slot %0d: digit=%0d fs=%0d to=%0d len=%0d low=%0d first=%0d",
             slot_idx, cur_digit, cur_fs, cur_to, cyc, low_cnt, first_low);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL slot%0d_unexpected: got a slot, required none", slot_idx);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("slot%0d_digit", slot_idx), cur_digit, e.digit);
      chk($sformatf("slot%0d_frame_start", slot_idx), cur_fs, e.fs);
      chk($sformatf("slot%0d_load_timeout", slot_idx), cur_to, e.to);
      chk($sformatf("slot%0d_length", slot_idx), cyc, e.len);
      chk($sformatf("slot%0d_low_cycles", slot_idx), low_cnt, e.low);
      chk($sformatf("slot%0d_first_low", slot_idx), first_low, e.first);
      chk($sformatf("slot%0d_stray_pulses", slot_idx), stray, 0);
    end
  endtask

  // Monitor: a flush closes an aborted slot, load_req opens a new one
  initial begin
    forever begin
      @(negedge sysclk);
      if (flush_seen != flush_cnt) begin
        flush_seen = flush_cnt;
        if (open) finalize();
        open = 0;
      end
      if (load_req === 1'b1) begin
        if (open) finalize();
        open      = 1;
        cur_digit = int'(digit_sel);
        cur_fs    = int'(frame_start);
        cur_to    = int'(load_timeout);
        cyc       = 0;
        low_cnt   = 0;
        first_low = -1;
        stray     = 0;
      end
      if (open) begin
        if (blank !== 1'b1) begin
          low_cnt++;
          if (first_low < 0) first_low = cyc;
        end
        if (cyc > 0 && (frame_start !== 1'b0 || load_timeout !== 1'b0)) stray++;
        cyc++;
      end
    end
  end

  task automatic wait_start(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (load_req !== 1'b1 && n < 200);
    if (load_req !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: got no load_req within 200 cycles, required one", name);
    end
  endtask

  // Runs cycles of the current slot; returns early inside cycle end_at
  task automatic slot(input int ld_at, input int chg_at, input logic [6:0] chg_val, input int end_at);
    for (int c = 0; c < CD; c++) begin
      if (c == end_at) begin
        load_done = 1'b0;
        return;
      end
      load_done = (c == ld_at);
      if (c == chg_at) brightness = chg_val;
      tick();
    end
    load_done = 1'b0;
  endtask

  initial begin
    int  n, len2, low2, first2;
    bit  done;
    rst_n = 1'b0; en = 1'b1; brightness = 7'd50; load_done = 1'b0;
    en2 = 1'b1; brightness2 = 7'd20; load_done2 = 1'b0;
    repeat (3) tick();
    chk("reset_digit_sel", digit_sel, 0);
    chk("reset_blank", blank, 1);
    chk("reset_load_req", load_req, 0);
    chk("reset_frame_start", frame_start, 0);
    chk("reset_load_timeout", load_timeout, 0);

    rst_n = 1'b1;
    push(0, 1, 0, 100, 45, 55);  wait_start("first_start");
    slot(2, 99, 7'd100, 100);
    push(1, 0, 0, 100, 95, 5);   slot(2, 99, 7'd0, 100);
    push(2, 0, 0, 100, 0, -1);   slot(2, 99, 7'd127, 100);
    push(0, 1, 0, 100, 95, 5);   slot(2, 99, 7'd50, 100);
    push(1, 0, 0, 100, 29, 71);  slot(70, -1, 7'd0, 100);
    push(2, 0, 0, 100, 0, -1);   slot(-1, -1, 7'd0, 100);
    push(0, 1, 1, 100, 45, 55);  slot(2, 30, 7'd10, 100);
    push(1, 0, 0, 100, 5, 95);   slot(2, 99, 7'd50, 100);
    push(2, 0, 0, 41, 0, -1);    slot(-1, -1, 7'd0, 40);

    en = 1'b0;
    tick();
    flush_cnt++;
    chk("idle_blank", blank, 1);
    chk("idle_digit_sel", digit_sel, 0);
    chk("idle_load_req", load_req, 0);
    chk("idle_frame_start", frame_start, 0);
    chk("idle_load_timeout", load_timeout, 0);
    repeat (3) tick();
    chk("idle_hold_digit_sel", digit_sel, 0);
    chk("idle_hold_blank", blank, 1);

    en = 1'b1;
    push(0, 1, 0, 100, 45, 55);  wait_start("restart");
    slot(2, 99, 7'd100, 100);
    push(1, 0, 0, 100, 0, -1);   slot(99, -1, 7'd0, 100);
    push(2, 0, 0, 100, 0, -1);   slot(-1, -1, 7'd0, 100);
    push(0, 1, 1, 100, 95, 5);   slot(0, -1, 7'd0, 100);
    push(1, 0, 0, 50, 45, 5);    slot(2, -1, 7'd0, 50);

    #2;
    chk("pre_reset_blank", blank, 0);
    rst_n = 1'b0;
    flush_cnt++;
    #1;
    chk("async_reset_blank", blank, 1);
    chk("async_reset_load_req", load_req, 0);
    chk("async_reset_digit_sel", digit_sel, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    push(0, 1, 0, 100, 95, 5);   wait_start("post_reset_start");
    slot(2, -1, 7'd0, 99);
    en = 1'b0;
    tick();
    flush_cnt++;

    // Default-parameter instance: brightness 20 gives R=9617
    n = 0;
    while (load_req2 !== 1'b1 && n < 13000) begin
      tick();
      n++;
    end
    if (load_req2 !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ref_start: got no load_req within 13000 cycles, required one");
    end else begin
      len2 = 0; low2 = 0; first2 = -1; done = 0;
      for (int k = 0; k < 13000 && !done; k++) begin
        if (k > 0 && load_req2 === 1'b1) begin
          done = 1;
        end else begin
          if (blank2 !== 1'b1) begin
            low2++;
            if (first2 < 0) first2 = k;
          end
          load_done2 = (k == 2);
          tick();
          len2++;
        end
      end
      load_done2 = 1'b0;
      $display("ref slot: len=%0d low=%0d first=%0d", len2, low2, first2);
      chk("ref_slot_length", len2, 12000);
      chk("ref_low_cycles", low2, 2383);
      chk("ref_first_low", first2, 9617);
      chk("ref_load_timeout", load_timeout2, 0);
      chk("ref_frame_start", frame_start2, (digit_sel2 == 2'd0) ? 1 : 0);
    end

    repeat (2) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
